// File: rtl/cache_ram_responder_pkg.sv
// cache_ram_responder_pkg
// Shared definitions for the cache RAM responder:
//   - responder state encoding (RESP_IDLE / RESP_WAIT / RESP_RESP)
//   - default line geometry (words per line, lines in store)
//   - word width and a helper that returns the line width in bits
package cache_ram_responder_pkg;

  localparam int WORD_W              = 32;
  localparam int DEF_OFFSET_WIDTH    = 3;
  localparam int DEF_LINE_ADDR_WIDTH = 10;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_RESP = 2'd2
  } resp_state_t;

  function automatic int line_width(input int offset_width);
    return WORD_W * (2 ** offset_width);
  endfunction

endpackage

// File: rtl/cache_ram_responder_mem_line_array.sv
// mem_line_array
// Backing line store: 2**LINE_ADDR_WIDTH lines of 2**OFFSET_WIDTH 32-bit words.
// Line-wide synchronous read (registered output, held while i_rd_en is low),
// single-word write with word select. Contents are not reset.
// Ports:
//   clk         clock
//   i_rd_en     capture line i_rd_index into o_rd_line on this edge
//   i_rd_index  line index to read
//   o_rd_line   registered read line
//   i_wr_en     write one word on this edge
//   i_wr_index  line index to write
//   i_wr_offset word within the line to write
//   i_wr_word   write data
module mem_line_array
  import cache_ram_responder_pkg::*;
#(
  parameter int OFFSET_WIDTH    = DEF_OFFSET_WIDTH,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   i_rd_en,
  input  logic [LINE_ADDR_WIDTH-1:0]             i_rd_index,
  output logic [WORD_W*(2**OFFSET_WIDTH)-1:0]    o_rd_line,
  input  logic                                   i_wr_en,
  input  logic [LINE_ADDR_WIDTH-1:0]             i_wr_index,
  input  logic [OFFSET_WIDTH-1:0]                i_wr_offset,
  input  logic [WORD_W-1:0]                      i_wr_word
);

  localparam int LINE_W = WORD_W * (2 ** OFFSET_WIDTH);
  localparam int DEPTH  = 2 ** LINE_ADDR_WIDTH;

  logic [LINE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_index][{i_wr_offset, 5'b0} +: WORD_W] <= i_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      o_rd_line <= r_mem[i_rd_index];
    end
  end

endmodule

// File: rtl/cache_ram_responder.sv
// cache_ram_responder
// Memory-side responder for the cache manager's RAM request port. One word
// beat per request: reads return the whole line holding the address, writes
// commit one word of the written-back line. Each beat ends with a one-cycle
// ram_ready pulse LATENCY cycles after acceptance.
// Optional feature macro: RAM_LINE_BUFFER_EN -- one-line read buffer; a read
// hitting the buffered line completes one cycle after acceptance.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ram_en_out      request valid (sampled only in IDLE)
//   ram_write_out   1 = write beat, 0 = read beat
//   ram_addr_out    word address: [2:0] offset, [12:3] line index, rest ignored
//   dc_data_wb      written-back line; write beat stores the word at the offset
//   ram_ready       one-cycle completion pulse
//   block_from_ram  line returned by the most recent read
//
// state     | meaning
// ----------+-------------------------------------------
// RESP_IDLE | no request in progress, inputs sampled
// RESP_WAIT | latency countdown
// RESP_RESP | ram_ready high; write commits leaving here
module cache_ram_responder
  import cache_ram_responder_pkg::*;
#(
  parameter int OFFSET_WIDTH    = DEF_OFFSET_WIDTH,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter int LATENCY         = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ram_en_out,
  input  logic                                ram_write_out,
  input  logic [29:0]                         ram_addr_out,
  input  logic [WORD_W*(2**OFFSET_WIDTH)-1:0] dc_data_wb,
  output logic                                ram_ready,
  output logic [WORD_W*(2**OFFSET_WIDTH)-1:0] block_from_ram
);

  localparam int LINE_W = WORD_W * (2 ** OFFSET_WIDTH);

  resp_state_t                r_state;
  resp_state_t                w_next_state;
  logic [CNT_W-1:0]           r_count;
  logic                       r_write;
  logic [LINE_ADDR_WIDTH-1:0] r_index;
  logic [OFFSET_WIDTH-1:0]    r_offset;
  logic [LINE_W-1:0]          r_block;

  logic [LINE_ADDR_WIDTH-1:0] w_req_index;
  logic [OFFSET_WIDTH-1:0]    w_req_offset;
  logic                       w_accept;
  logic                       w_hit;
  logic [LINE_W-1:0]          w_hit_line;
  logic                       w_mem_rd_en;
  logic                       w_mem_wr_en;
  logic [LINE_W-1:0]          w_mem_rdata;
  logic [WORD_W-1:0]          w_wr_word;
  logic                       w_store_load;
  logic                       w_hit_load;
  logic                       w_unused_addr;

  assign w_req_offset  = ram_addr_out[OFFSET_WIDTH-1:0];
  assign w_req_index   = ram_addr_out[OFFSET_WIDTH +: LINE_ADDR_WIDTH];
  // Upper address bits alias onto the same lines.
  assign w_unused_addr = ^ram_addr_out[29:OFFSET_WIDTH+LINE_ADDR_WIDTH];

  assign w_accept  = (r_state == RESP_IDLE) && ram_en_out;
  assign w_wr_word = dc_data_wb[{r_offset, 5'b0} +: WORD_W];

`ifdef RAM_LINE_BUFFER_EN
  logic                       r_buf_valid;
  logic [LINE_ADDR_WIDTH-1:0] r_buf_index;
  logic [LINE_W-1:0]          r_buf_line;

  assign w_hit      = r_buf_valid && !ram_write_out && (r_buf_index == w_req_index);
  assign w_hit_line = r_buf_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_index <= '0;
    end else if (w_store_load) begin
      r_buf_valid <= 1'b1;
      r_buf_index <= r_index;
    end
  end

  // Keep the buffered copy coherent with committed writes to its line.
  always_ff @(posedge clk) begin
    if (w_store_load) begin
      r_buf_line <= w_mem_rdata;
    end else if (w_mem_wr_en && r_buf_valid && (r_buf_index == r_index)) begin
      r_buf_line[{r_offset, 5'b0} +: WORD_W] <= w_wr_word;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_line = '0;
`endif

  // The store is read at acceptance so the line is waiting in the array's
  // output register by the time the countdown ends; a preceding write has
  // already committed on the edge that left RESP.
  assign w_mem_rd_en  = w_accept && !ram_write_out;
  assign w_mem_wr_en  = (r_state == RESP_RESP) && r_write && !rst;
  assign w_store_load = (r_state == RESP_WAIT) && (r_count == CNT_W'(1)) && !r_write;
  assign w_hit_load   = w_accept && w_hit;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RESP_IDLE: begin
        if (ram_en_out) begin
          w_next_state = w_hit ? RESP_RESP : RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        if (r_count == CNT_W'(1)) begin
          w_next_state = RESP_RESP;
        end
      end
      RESP_RESP: w_next_state = RESP_IDLE;
      default:   w_next_state = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RESP_IDLE;
      r_count  <= '0;
      r_write  <= 1'b0;
      r_index  <= '0;
      r_offset <= '0;
      r_block  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write  <= ram_write_out;
        r_index  <= w_req_index;
        r_offset <= w_req_offset;
        r_count  <= CNT_W'(LATENCY - 1);
      end else if (r_state == RESP_WAIT) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_store_load) begin
        r_block <= w_mem_rdata;
      end else if (w_hit_load) begin
        r_block <= w_hit_line;
      end
    end
  end

  mem_line_array #(
    .OFFSET_WIDTH    (OFFSET_WIDTH),
    .LINE_ADDR_WIDTH (LINE_ADDR_WIDTH)
  ) u_store (
    .clk         (clk),
    .i_rd_en     (w_mem_rd_en),
    .i_rd_index  (w_req_index),
    .o_rd_line   (w_mem_rdata),
    .i_wr_en     (w_mem_wr_en),
    .i_wr_index  (r_index),
    .i_wr_offset (r_offset),
    .i_wr_word   (w_wr_word)
  );

  assign ram_ready      = (r_state == RESP_RESP);
  assign block_from_ram = r_block;

endmodule

// File: tb/tb_cache_ram_responder.sv
module tb_cache_ram_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         ram_en_out;
  logic         ram_write_out;
  logic [29:0]  ram_addr_out;
  logic [255:0] dc_data_wb;
  logic         ram_ready;
  logic [255:0] block_from_ram;

  int checks = 0;
  int errors = 0;

  // Reference model: store as words keyed by line*8+offset, plus the last
  // line returned by a read and the buffered-line bookkeeping.
  logic [31:0]  model [int];
  logic [255:0] exp_block;
  bit           buf_valid;
  int           buf_idx;

  cache_ram_responder #(.LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_en_out     (ram_en_out),
    .ram_write_out  (ram_write_out),
    .ram_addr_out   (ram_addr_out),
    .dc_data_wb     (dc_data_wb),
    .ram_ready      (ram_ready),
    .block_from_ram (block_from_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_line(input int idx);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++)
      if (model.exists(idx * 8 + k)) l[k*32 +: 32] = model[idx * 8 + k];
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [29:0] mk_addr(input int hi, input int idx, input int off);
    logic [29:0] a;
    a = (30'(hi) << 13) | (30'(idx % 1024) << 3) | 30'(off % 8);
    return a;
  endfunction

  // Called just after a rising edge while the DUT is idle; returns just after
  // the rising edge that leaves the response cycle, with ram_en_out still high
  // unless this is the last beat of a burst.
  task automatic do_beat(input bit wr, input logic [29:0] addr, input logic [255:0] wdata,
                         input bit last);
    int idx, off, lat_exp, n;
    idx = int'((addr >> 3) % 30'd1024);
    off = int'(addr % 30'd8);
    lat_exp = LAT;
`ifdef RAM_LINE_BUFFER_EN
    if (!wr && buf_valid && buf_idx == idx) lat_exp = 1;
`endif
    ram_en_out    = 1'b1;
    ram_write_out = wr;
    ram_addr_out  = addr;
    dc_data_wb    = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      // Request lines are don't-care after acceptance; scramble them.
      if (!ram_ready && ($urandom % 2 == 0)) begin
        ram_addr_out  = 30'($urandom);
        ram_write_out = 1'($urandom);
      end
    end while (!ram_ready && n < 40);
    check("latency", 256'(n), 256'(lat_exp));
    if (wr) begin
      check("wr_block_held", block_from_ram, exp_block);
      model[idx * 8 + off] = wdata[off*32 +: 32];
    end else begin
      exp_block = exp_line(idx);
      buf_valid = 1'b1;
      buf_idx   = idx;
      check("rd_block", block_from_ram, exp_block);
    end
    @(posedge clk); #1;
    check("ready_single", 256'(ram_ready), 256'(0));
    if (last) ram_en_out = 1'b0;
  endtask

  task automatic fill_line(input int idx);
    logic [255:0] l;
    l = rand_line();
    for (int k = 0; k < 8; k++) do_beat(1'b1, mk_addr(0, idx, k), l, k == 7);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 256'(ram_ready), 256'(0));
    end
  endtask

  initial begin
    logic [255:0] wd;
    int lines [5];
    lines = '{0, 2, 4, 5, 9};
    rst = 1'b1;
    ram_en_out = 1'b0;
    ram_write_out = 1'b0;
    ram_addr_out = '0;
    dc_data_wb = '0;
    exp_block = '0;
    buf_valid = 1'b0;
    buf_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state then idle
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 256'(ram_ready), 256'(0));
      check("rst_block", block_from_ram, 256'(0));
    end

    foreach (lines[i]) fill_line(lines[i]);

    // Write word 3 of line 2, then read the line back
    wd = rand_line();
    wd[3*32 +: 32] = 32'hDEADBEEF;
    do_beat(1'b1, 30'h13, wd, 1'b1);
    idle(2);
    do_beat(1'b0, 30'h10, '0, 1'b1);
    check("rd_word3", 256'(block_from_ram[3*32 +: 32]), 256'(32'hDEADBEEF));
    idle(1);

    // Held-enable 8-beat line fill from line 5, offsets 7..0
    for (int k = 7; k >= 0; k--) do_beat(1'b0, mk_addr(0, 5, k), '0, k == 0);
    idle(1);

    // Aliasing: upper address bits ignored
    wd = rand_line();
    wd[31:0] = 32'h12345678;
    do_beat(1'b1, 30'h2000, wd, 1'b1);
    do_beat(1'b0, 30'h0, '0, 1'b1);
    check("alias_word0", 256'(block_from_ram[31:0]), 256'(32'h12345678));
    idle(1);

    // Reset in the countdown of a write: write dropped, no ready
    ram_en_out    = 1'b1;
    ram_write_out = 1'b1;
    ram_addr_out  = 30'h21;
    dc_data_wb    = ~exp_line(4);
    @(posedge clk); #1;
    check("wait_ready", 256'(ram_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    ram_en_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_mid_ready", 256'(ram_ready), 256'(0));
    end
    rst = 1'b0;
    exp_block = '0;
    buf_valid = 1'b0;
    check("rst_mid_block", block_from_ram, 256'(0));
    idle(2);
    do_beat(1'b0, 30'h20, '0, 1'b1);
    idle(1);

    // Randomized mix over the filled lines, with aliased upper bits and gaps
    for (int t = 0; t < 80; t++) begin
      bit wr, last;
      int li;
      wr = 1'($urandom);
      li = lines[$urandom_range(0, 4)];
      last = ($urandom % 4 == 0);
      do_beat(wr, mk_addr(int'($urandom % 131072), li, int'($urandom % 8)), rand_line(), last);
      if (last) idle(int'($urandom_range(0, 3)));
    end
    ram_en_out = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
